// File: rtl/fabric_temporal_pkg.sv
`default_nettype none
// ============================================================================
// Module : fabric_temporal_pkg
// Brief  : Shared error codes and scheduler state type for the temporal PE.
// Rev    : 1.0
// ============================================================================
package fabric_temporal_pkg;

  localparam logic [15:0] ERR_DUP_TAG   = 16'h0001;
  localparam logic [15:0] ERR_NO_MATCH  = 16'h0002;
  localparam logic [15:0] ERR_CREDIT_OV = 16'h0003;

  typedef enum logic {SCHED_RUN, SCHED_HALT} sched_state_t;

endpackage
`default_nettype wire

// File: rtl/temporal_pe_tag_match.sv
`default_nettype none
// ============================================================================
// Module : temporal_pe_tag_match
// Brief  : Combinational head-tag matcher: onehot select, dup and no-match flags.
// Rev    : 1.0
// ============================================================================
module temporal_pe_tag_match
  import fabric_temporal_pkg::*;
#(
  parameter int NUM_IN   = 2,
  parameter int NUM_INSN = 4,
  parameter int TAG_W    = 4,
  parameter int SLOT_W   = (NUM_INSN > 1) ? $clog2(NUM_INSN) : 1
) (
  input  logic [NUM_INSN-1:0]        cfg_slot_en,
  input  logic [NUM_INSN*TAG_W-1:0]  cfg_slot_tag,
  input  logic [NUM_INSN*NUM_IN-1:0] cfg_slot_opm,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*TAG_W-1:0]    in_tag,
  output logic [NUM_INSN-1:0]        sel_onehot,
  output logic [SLOT_W-1:0]          sel_idx,
  output logic                       one_match,
  output logic                       dup,
  output logic                       no_match
);

  logic [NUM_INSN-1:0][NUM_IN-1:0] w_tag_eq;
  logic [NUM_INSN-1:0][NUM_IN-1:0] w_port_ok;
  logic [NUM_IN-1:0][NUM_INSN-1:0] w_use_t;
  logic [NUM_IN-1:0]               w_orphan;
  logic [NUM_INSN-1:0]             w_match;

  for (genvar i = 0; i < NUM_INSN; i++) begin : g_slot
    for (genvar p = 0; p < NUM_IN; p++) begin : g_port
      assign w_tag_eq[i][p]  = (in_tag[p*TAG_W +: TAG_W] == cfg_slot_tag[i*TAG_W +: TAG_W]);
      assign w_port_ok[i][p] = !cfg_slot_opm[i*NUM_IN+p] || (in_valid[p] && w_tag_eq[i][p]);
      // transposed so each port can ask "does any enabled slot claim this tag"
      assign w_use_t[p][i]   = cfg_slot_en[i] && cfg_slot_opm[i*NUM_IN+p] && w_tag_eq[i][p];
    end
    assign w_match[i] = cfg_slot_en[i] && (&w_port_ok[i]);
  end

  for (genvar p = 0; p < NUM_IN; p++) begin : g_orphan
    assign w_orphan[p] = in_valid[p] && !(|w_use_t[p]);
  end

  assign no_match   = |w_orphan;
  assign one_match  = (w_match != '0) && ((w_match & (w_match - 1'b1)) == '0);
  assign sel_onehot = one_match ? w_match : '0;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_INSN; i++) begin
      if (w_match[i]) sel_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_INSN; i++) begin
      for (int j = i + 1; j < NUM_INSN; j++) begin
        if (cfg_slot_en[i] && cfg_slot_en[j] &&
            (cfg_slot_tag[i*TAG_W +: TAG_W] == cfg_slot_tag[j*TAG_W +: TAG_W]) &&
            ((cfg_slot_opm[i*NUM_IN +: NUM_IN] & cfg_slot_opm[j*NUM_IN +: NUM_IN]) != '0))
          dup = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/temporal_pe_sched.sv
`default_nettype none
// ============================================================================
// Module : temporal_pe_sched
// Brief  : Credit-gated instruction scheduler for a temporal PE with sticky errors.
// Rev    : 1.0
// ============================================================================
module temporal_pe_sched
  import fabric_temporal_pkg::*;
#(
  parameter int NUM_IN   = 2,
  parameter int NUM_INSN = 4,
  parameter int TAG_W    = 4,
  parameter int CREDITS  = 2,
  localparam int SLOT_W  = (NUM_INSN > 1) ? $clog2(NUM_INSN) : 1,
  localparam int CRED_W  = $clog2(CREDITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_INSN-1:0]        cfg_slot_en,
  input  logic [NUM_INSN*TAG_W-1:0]  cfg_slot_tag,
  input  logic [NUM_INSN*NUM_IN-1:0] cfg_slot_opm,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN*TAG_W-1:0]    in_tag,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       fu_fire,
  output logic [SLOT_W-1:0]          fu_slot,
  output logic [TAG_W-1:0]           fu_tag,
  input  logic                       out_fire,
  output logic [CRED_W-1:0]          credits,
  output logic                       error_valid,
  output logic [15:0]                error_code
);

  localparam logic [CRED_W-1:0] c_CRED_MAX = CRED_W'(CREDITS);

  sched_state_t         r_state, w_state_next;
  logic [CRED_W-1:0]    r_credits;
  logic                 r_fu_fire;
  logic [SLOT_W-1:0]    r_fu_slot;
  logic [TAG_W-1:0]     r_fu_tag;
  logic                 r_error_valid;
  logic [15:0]          r_error_code;

  logic [NUM_INSN-1:0]  w_onehot;
  logic [SLOT_W-1:0]    w_sel;
  logic                 w_one, w_dup, w_nomatch;
  logic [NUM_IN-1:0]    w_sel_opm;
  logic [TAG_W-1:0]     w_sel_tag;
  logic                 w_issue, w_ret, w_ov, w_err_any;
  logic [15:0]          w_err_code;

  temporal_pe_tag_match #(
    .NUM_IN   (NUM_IN),
    .NUM_INSN (NUM_INSN),
    .TAG_W    (TAG_W),
    .SLOT_W   (SLOT_W)
  ) u_match (
    .cfg_slot_en  (cfg_slot_en),
    .cfg_slot_tag (cfg_slot_tag),
    .cfg_slot_opm (cfg_slot_opm),
    .in_valid     (in_valid),
    .in_tag       (in_tag),
    .sel_onehot   (w_onehot),
    .sel_idx      (w_sel),
    .one_match    (w_one),
    .dup          (w_dup),
    .no_match     (w_nomatch)
  );

  always_comb begin
    w_sel_opm = '0;
    w_sel_tag = '0;
    for (int i = 0; i < NUM_INSN; i++) begin
      if (w_onehot[i]) begin
        w_sel_opm = w_sel_opm | cfg_slot_opm[i*NUM_IN +: NUM_IN];
        w_sel_tag = w_sel_tag | cfg_slot_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Gating uses the credit count before this cycle's return.
  assign w_issue   = (r_state == SCHED_RUN) && (r_credits != '0) && w_one;
  assign w_ov      = out_fire && (r_credits == c_CRED_MAX);
  assign w_ret     = out_fire && !w_ov;
  assign w_err_any = w_dup || w_nomatch || w_ov;
  assign w_err_code = w_dup     ? ERR_DUP_TAG  :
                      w_nomatch ? ERR_NO_MATCH :
                      w_ov      ? ERR_CREDIT_OV : 16'h0000;

  always_comb begin
    w_state_next = r_state;
    in_ready     = '0;
    if (w_issue) in_ready = w_sel_opm;
    if ((r_state == SCHED_RUN) && w_err_any) w_state_next = SCHED_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SCHED_RUN;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits     <= c_CRED_MAX;
      r_fu_fire     <= 1'b0;
      r_fu_slot     <= '0;
      r_fu_tag      <= '0;
      r_error_valid <= 1'b0;
      r_error_code  <= 16'h0000;
    end else begin
      r_fu_fire <= w_issue;
      if (w_issue) begin
        r_fu_slot <= w_sel;
        r_fu_tag  <= w_sel_tag;
      end
      if (w_issue && !w_ret)      r_credits <= r_credits - 1'b1;
      else if (!w_issue && w_ret) r_credits <= r_credits + 1'b1;
      if ((r_state == SCHED_RUN) && w_err_any) begin
        r_error_valid <= 1'b1;
        r_error_code  <= w_err_code;
      end
    end
  end

  assign fu_fire     = r_fu_fire;
  assign fu_slot     = r_fu_slot;
  assign fu_tag      = r_fu_tag;
  assign credits     = r_credits;
  assign error_valid = r_error_valid;
  assign error_code  = r_error_code;

endmodule
`default_nettype wire

// File: tb/tb_temporal_pe_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_temporal_pe_sched
// Brief  : Directed-vector scoreboard bench for temporal_pe_sched.
// Rev    : 1.0
// ============================================================================
module tb_temporal_pe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cfg_slot_en;
  logic [15:0] cfg_slot_tag;
  logic [7:0]  cfg_slot_opm;
  logic [1:0]  in_valid;
  logic [7:0]  in_tag;
  logic [1:0]  in_ready;
  logic        fu_fire;
  logic [1:0]  fu_slot;
  logic [3:0]  fu_tag;
  logic        out_fire;
  logic [1:0]  credits;
  logic        error_valid;
  logic [15:0] error_code;

  typedef struct {
    int         due;
    logic [1:0] slot;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  temporal_pe_sched dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_slot_en  (cfg_slot_en),
    .cfg_slot_tag (cfg_slot_tag),
    .cfg_slot_opm (cfg_slot_opm),
    .in_valid     (in_valid),
    .in_tag       (in_tag),
    .in_ready     (in_ready),
    .fu_fire      (fu_fire),
    .fu_slot      (fu_slot),
    .fu_tag       (fu_tag),
    .out_fire     (out_fire),
    .credits      (credits),
    .error_valid  (error_valid),
    .error_code   (error_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stimulus cycle: drive heads, check the pop strobe, queue the expected FU issue.
  task automatic apply(input string nm, input logic [1:0] v, input logic [3:0] t0,
                       input logic [3:0] t1, input logic of, input logic [1:0] rdy,
                       input logic [1:0] slot, input logic [3:0] tag);
    in_valid = v;
    in_tag   = {t1, t0};
    out_fire = of;
    #1;
    chk({nm, "_ready"}, 32'(in_ready), 32'(rdy));
    if (rdy != 2'b00) sb.push_back('{cyc + 1, slot, tag});
    tick();
    in_valid = 2'b00;
    out_fire = 1'b0;
  endtask

  always @(negedge clk) begin
    if (fu_fire === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL fu_fire_unexpected: got slot=%0d tag=%0h, expected no issue", fu_slot, fu_tag);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.due != cyc || fu_slot !== mon_e.slot || fu_tag !== mon_e.tag) begin
          bad++;
          $display("FAIL fu_issue: got cyc=%0d slot=%0d tag=%0h expected cyc=%0d slot=%0d tag=%0h",
                   cyc, fu_slot, fu_tag, mon_e.due, mon_e.slot, mon_e.tag);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      total++;
      bad++;
      mon_e = sb.pop_front();
      $display("FAIL fu_issue_missing: got no fu_fire expected slot=%0d tag=%0h", mon_e.slot, mon_e.tag);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // slot3..0: tag 3/7/3/5, opm 01/10/11/01; slot3 disabled until the dup test
    cfg_slot_en  = 4'b0111;
    cfg_slot_tag = {4'h3, 4'h7, 4'h3, 4'h5};
    cfg_slot_opm = {2'b01, 2'b10, 2'b11, 2'b01};
    in_valid     = 2'b00;
    in_tag       = 8'h00;
    out_fire     = 1'b0;

    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_error_valid", 32'(error_valid), 32'd0);
    chk("rst_error_code", 32'(error_code), 32'd0);
    chk("rst_credits", 32'(credits), 32'd2);
    chk("rst_fu_fire", 32'(fu_fire), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    apply("single", 2'b11, 4'h3, 4'h3, 1'b0, 2'b11, 2'd1, 4'h3);
    chk("single_credits", 32'(credits), 32'd1);
    apply("ret0", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("ret0_credits", 32'(credits), 32'd2);

    apply("stall_a", 2'b11, 4'h3, 4'h3, 1'b0, 2'b11, 2'd1, 4'h3);
    apply("stall_b", 2'b11, 4'h3, 4'h3, 1'b0, 2'b11, 2'd1, 4'h3);
    chk("stall_credits0", 32'(credits), 32'd0);
    apply("stall_c", 2'b11, 4'h3, 4'h3, 1'b0, 2'b00, 2'd0, 4'h0);
    apply("stall_ret", 2'b11, 4'h3, 4'h3, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("stall_ret_credits", 32'(credits), 32'd1);
    apply("stall_go", 2'b11, 4'h3, 4'h3, 1'b0, 2'b11, 2'd1, 4'h3);
    chk("stall_end_credits", 32'(credits), 32'd0);

    apply("ret1", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("ret1_credits", 32'(credits), 32'd1);
    apply("iss_ret", 2'b11, 4'h3, 4'h3, 1'b1, 2'b11, 2'd1, 4'h3);
    chk("iss_ret_credits", 32'(credits), 32'd1);
    apply("ret2", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("ret2_credits", 32'(credits), 32'd2);

    apply("slot0", 2'b01, 4'h5, 4'h0, 1'b0, 2'b01, 2'd0, 4'h5);
    chk("slot0_credits", 32'(credits), 32'd1);
    apply("slot2", 2'b10, 4'h0, 4'h7, 1'b1, 2'b10, 2'd2, 4'h7);
    chk("slot2_credits", 32'(credits), 32'd1);
    apply("two_match", 2'b11, 4'h5, 4'h7, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("two_match_credits", 32'(credits), 32'd2);
    chk("two_match_err", 32'(error_valid), 32'd0);

    apply("partial", 2'b01, 4'h3, 4'h0, 1'b0, 2'b00, 2'd0, 4'h0);
    chk("partial_err", 32'(error_valid), 32'd0);
    apply("partial_done", 2'b11, 4'h3, 4'h3, 1'b0, 2'b11, 2'd1, 4'h3);
    chk("partial_credits", 32'(credits), 32'd1);

    // port0 tag 9 is claimed by no slot, while port1 still completes slot2
    apply("nomatch", 2'b11, 4'h9, 4'h7, 1'b0, 2'b10, 2'd2, 4'h7);
    chk("nomatch_valid", 32'(error_valid), 32'd1);
    chk("nomatch_code", 32'(error_code), 32'h0002);
    chk("nomatch_credits", 32'(credits), 32'd0);
    apply("halt", 2'b11, 4'h3, 4'h3, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("halt_credits", 32'(credits), 32'd1);
    apply("halt_ret", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("halt_ret_credits", 32'(credits), 32'd2);
    apply("halt_ov", 2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 2'd0, 4'h0);
    chk("halt_ov_credits", 32'(credits), 32'd2);
    chk("halt_ov_code", 32'(error_code), 32'h0002);

    rst = 1'b1;
    tick();
    chk("rst2_fu_fire", 32'(fu_fire), 32'd0);
    chk("rst2_error_valid", 32'(error_valid), 32'd0);
    rst = 1'b0;
    cfg_slot_en = 4'b1111;
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    chk("dup_ov_valid", 32'(error_valid), 32'd1);
    chk("dup_ov_code", 32'(error_code), 32'h0001);
    chk("dup_ov_credits", 32'(credits), 32'd2);
    repeat (3) tick();
    chk("dup_sticky_code", 32'(error_code), 32'h0001);
    rst = 1'b1;
    cfg_slot_en = 4'b0111;
    tick();
    rst = 1'b0;
    tick();
    chk("rst3_error_valid", 32'(error_valid), 32'd0);
    chk("rst3_error_code", 32'(error_code), 32'd0);
    chk("rst3_credits", 32'(credits), 32'd2);

    repeat (2) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
